gray_window3x3: RTL and testbench

//  - Consumes the raster grayscale pixel stream from the convolution pixel stage (one pixel per
//    pix_valid strobe) and emits complete 3x3 neighbourhoods for the downstream kernel/classifier.
//  - Holds the two previous image rows in line buffers and keeps a 3x3 shift window.
//  - No backpressure; the upstream stage may strobe at any duty cycle (e.g. every other clk).

---
 rtl/gray_window3x3.sv | 109 ++++++++++
 tb/tb_gray_window3x3.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gray_window3x3.sv
// 3x3 neighbourhood generator for a raster grayscale stream: two line buffers plus a shifting window.
// Optional macro CONV_WIN_COORD_EN adds the win_x/win_y centre-coordinate outputs.
module gray_window3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_in,
    output logic                 win_valid,
    output logic [9*PIX_W-1:0]   win,
    output logic                 frame_done
`ifdef CONV_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

    state_t             state;
    logic [XW-1:0]      in_x;
    logic [YW-1:0]      in_y;
    logic [PIX_W-1:0]   lb0 [IMG_W];
    logic [PIX_W-1:0]   lb1 [IMG_W];
    // Window columns, each packed {bottom, middle, top}; col0 is the leftmost.
    logic [3*PIX_W-1:0] col0_p0, col1_p0, col2_p0;
    logic [3*PIX_W-1:0] col_new;
    logic [9*PIX_W-1:0] win_next;
    logic               accept;
    logic               emit;

    assign accept  = pix_valid && !frame_done;
    assign col_new = {pix_in, lb0[in_x], lb1[in_x]};
    // RUN means the current row is >= 2; columns 0/1 would straddle the row wrap.
    assign emit    = accept && (state == RUN) && (in_x >= XW'(2));

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[(r*3+0)*PIX_W +: PIX_W] = col1_p0[r*PIX_W +: PIX_W];
            win_next[(r*3+1)*PIX_W +: PIX_W] = col2_p0[r*PIX_W +: PIX_W];
            win_next[(r*3+2)*PIX_W +: PIX_W] = col_new[r*PIX_W +: PIX_W];
        end
    end

    // Stage p0: line buffers and window shift register (pure data movement)
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[in_x] <= lb0[in_x];
            lb0[in_x] <= pix_in;
            col0_p0   <= col1_p0;
            col1_p0   <= col2_p0;
            col2_p0   <= col_new;
        end
    end

    // Stage p1: registered window output, raster counters and frame FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            in_x       <= '0;
            in_y       <= '0;
            win_valid  <= 1'b0;
            win        <= '0;
            frame_done <= 1'b0;
`ifdef CONV_WIN_COORD_EN
            win_x      <= '0;
            win_y      <= '0;
`endif
        end else begin
            win_valid <= emit;
            if (emit) begin
                win   <= win_next;
`ifdef CONV_WIN_COORD_EN
                win_x <= in_x - XW'(1);
                win_y <= in_y - YW'(1);
`endif
            end
            if (accept) begin
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    if (in_y != Y_LAST) in_y <= in_y + YW'(1);
                end else begin
                    in_x <= in_x + XW'(1);
                end
                case (state)
                    FILL: if (in_x == X_LAST && in_y == YW'(1)) state <= RUN;
                    RUN: begin
                        if (in_x == X_LAST && in_y == Y_LAST) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_window3x3.sv
// Bench for gray_window3x3 (8x6 image): directed frames plus randomized pixels/cadence vs an image-array model.
module tb_gray_window3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        win_valid;
    logic [71:0] win;
    logic        frame_done;
`ifdef CONV_WIN_COORD_EN
    logic [2:0]  win_x;
    logic [2:0]  win_y;
`endif

    gray_window3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .win_valid  (win_valid),
        .win        (win),
        .frame_done (frame_done)
`ifdef CONV_WIN_COORD_EN
        ,
        .win_x      (win_x),
        .win_y      (win_y)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the frame as a 2-D image, raster position and done flag.
    logic [7:0]  img [H][W];
    int          mx, my;
    bit          mdone;
    bit          exp_vld;
    logic [71:0] exp_win;
    int          exp_x, exp_y;
    int          nwin;
    logic [71:0] first_win;

    task automatic step(input bit v, input logic [7:0] p, input bit rst);
        reset     = rst;
        pix_valid = v;
        pix_in    = p;
        exp_vld   = 1'b0;
        if (rst) begin
            mx = 0; my = 0; mdone = 1'b0; exp_win = '0; exp_x = 0; exp_y = 0; nwin = 0;
        end else if (v && !mdone) begin
            img[my][mx] = p;
            if (mx >= 2 && my >= 2) begin
                exp_vld = 1'b1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        exp_win[(r*3+c)*8 +: 8] = img[my-2+r][mx-2+c];
                exp_x = mx - 1;
                exp_y = my - 1;
            end
            if (mx == W - 1) begin
                mx = 0;
                if (my == H - 1) mdone = 1'b1; else my++;
            end else begin
                mx++;
            end
        end
        @(posedge clk);
        #1;
        total++;
        assert (win_valid === exp_vld) else begin
            bad++; $error("FAIL win_valid got=%0b exp=%0b", win_valid, exp_vld);
        end
        total++;
        assert (win === exp_win) else begin
            bad++; $error("FAIL win got=%h exp=%h", win, exp_win);
        end
        total++;
        assert (frame_done === mdone) else begin
            bad++; $error("FAIL frame_done got=%0b exp=%0b", frame_done, mdone);
        end
`ifdef CONV_WIN_COORD_EN
        if (exp_vld) begin
            total++;
            assert (win_x === 3'(exp_x) && win_y === 3'(exp_y)) else begin
                bad++; $error("FAIL coord got=(%0d,%0d) exp=(%0d,%0d)", win_x, win_y, exp_x, exp_y);
            end
            total++;
            assert (win_x !== 3'd0 && win_x !== 3'd7) else begin
                bad++; $error("FAIL border_x got=%0d exp=1..6", win_x);
            end
        end
`endif
        if (win_valid) begin
            if (nwin == 0) first_win = win;
            nwin++;
        end
    endtask

    // mode 0: back-to-back, 1: every other cycle, 2: random cadence
    task automatic run_frame(input int base, input bit rnd_pix, input int mode, input int n_acc);
        int acc = 0;
        int guard = 0;
        bit v;
        logic [7:0] p;
        while (acc < n_acc && guard < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = $urandom_range(0, 1) == 1;
            endcase
            p = rnd_pix ? 8'($urandom) : 8'(base + my * W + mx);
            step(v, p, 1'b0);
            if (v) acc++;
            guard++;
        end
        step(1'b0, 8'h00, 1'b0);
        total++;
        assert (acc === n_acc) else begin
            bad++; $error("FAIL accept_budget got=%0d exp=%0d", acc, n_acc);
        end
    endtask

    task automatic check_frame(input string tag, input logic [71:0] first_exp, input bit chk_first);
        total++;
        assert (nwin === 24) else begin
            bad++; $error("FAIL %s win_count got=%0d exp=24", tag, nwin);
        end
        total++;
        assert (frame_done === 1'b1) else begin
            bad++; $error("FAIL %s frame_done_end got=%0b exp=1", tag, frame_done);
        end
        if (chk_first) begin
            total++;
            assert (first_win === first_exp) else begin
                bad++; $error("FAIL %s first_win got=%h exp=%h", tag, first_win, first_exp);
            end
        end
    endtask

    initial begin
        logic [71:0] last_a;
        last_a = 72'h2F2E2D_272625_1F1E1D;

        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Frame A: y*8+x back-to-back
        run_frame(0, 1'b0, 0, 48);
        check_frame("frameA", 72'h121110_0A0908_020100, 1'b1);
        total++;
        assert (win === last_a) else begin
            bad++; $error("FAIL last_win got=%h exp=%h", win, last_a);
        end

        // Strobes after frame_done are ignored
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
        total++;
        assert (win === last_a) else begin
            bad++; $error("FAIL win_after_done got=%h exp=%h", win, last_a);
        end

        // Reset together with pix_valid: pixel dropped; then every-other-cycle frame
        step(1'b1, 8'hAA, 1'b1);
        run_frame(0, 1'b0, 1, 48);
        check_frame("frameB", 72'h121110_0A0908_020100, 1'b1);

        // Abandon a frame after 20 accepts, then a +100 frame at random cadence
        step(1'b0, 8'h00, 1'b1);
        run_frame(0, 1'b0, 0, 20);
        step(1'b0, 8'h00, 1'b1);
        run_frame(100, 1'b0, 2, 48);
        check_frame("frameC", 72'h767574_6E6D6C_666564, 1'b1);

        // Random pixels, random cadence
        for (int f = 0; f < 2; f++) begin
            step(1'b0, 8'h00, 1'b1);
            run_frame(0, 1'b1, 2, 48);
            check_frame("frameR", '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
